// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Holds the framing state encoding, the latched per-frame configuration
// payload and the clocks-per-bit calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } tx_state_e;

    // Frame options captured when a word is popped
    typedef struct packed {
        logic parity_en;
        logic parity_bit;
        logic stop2;
    } frame_cfg_t;

    // Truncating division: the bit period is rounded down to whole clocks
    function automatic int unsigned clks_per_bit(input int unsigned clock_rate,
                                                 input int unsigned baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO used as the transmit word buffer.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push/wr_data: write a word (ignored when full)
//   pop         : drop the head word (ignored when empty)
//   rd_data_c   : head word, valid while not empty (combinational read)
//   full, empty : registered occupancy flags
//   count       : registered number of stored words
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_n;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign rd_data_c = mem[rd_ptr];

    // Occupancy update; simultaneous push and pop cancel
    always_comb begin
        count_n = count;
        case ({do_push, do_pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    // Storage needs no reset; contents are only read behind the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter with optional parity, 1/2 stop bits and break.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   s_valid/s_ready/s_data   : word write handshake into the TX buffer
//   parity_en, parity_mode   : parity enable, 0 = even / 1 = odd
//   stop_bits                : 0 = one stop bit, 1 = two
//   break_req                : hold the line low (break) when next idle
//   tx_serial                : registered serial line, idles high
//   tx_busy                  : registered, high while a frame or break runs
//   fifo_count               : words currently buffered
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 200_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          parity_en,
    input  logic                          parity_mode,
    input  logic                          stop_bits,
    input  logic                          break_req,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CPB     = clks_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned TIMER_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int unsigned IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(CPB - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DATA_BITS - 1);

    tx_state_e            state, state_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    frame_cfg_t           cfg, cfg_n;
    logic                 extra, extra_n;       // second stop / mark bit pending
    logic                 brk_mark, brk_mark_n; // break is in its trailing mark
    logic                 tx_n;
    logic                 timer_done;
    logic                 dispatch;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;

    assign s_ready    = !fifo_full;
    assign timer_done = (timer == '0);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_valid),
        .wr_data   (s_data),
        .pop       (fifo_pop),
        .rd_data_c (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            shreg     <= '0;
            bit_idx   <= '0;
            cfg       <= '0;
            extra     <= 1'b0;
            brk_mark  <= 1'b0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            shreg     <= shreg_n;
            bit_idx   <= bit_idx_n;
            cfg       <= cfg_n;
            extra     <= extra_n;
            brk_mark  <= brk_mark_n;
            tx_serial <= tx_n;
            tx_busy   <= (state_n != ST_IDLE);
        end
    end

    // Framing next-state; the line level is computed for the next state so
    // tx_serial changes on the same edge as the state
    always_comb begin
        state_n    = state;
        timer_n    = timer_done ? timer : timer - TIMER_W'(1);
        shreg_n    = shreg;
        bit_idx_n  = bit_idx;
        cfg_n      = cfg;
        extra_n    = extra;
        brk_mark_n = brk_mark;
        tx_n       = tx_serial;
        fifo_pop   = 1'b0;
        dispatch   = 1'b0;

        case (state)
            ST_IDLE: dispatch = 1'b1;

            ST_START: begin
                if (timer_done) begin
                    state_n   = ST_DATA;
                    timer_n   = TIMER_LOAD;
                    bit_idx_n = '0;
                    tx_n      = shreg[0];
                end
            end

            ST_DATA: begin
                if (timer_done) begin
                    timer_n = TIMER_LOAD;
                    if (bit_idx == LAST_IDX) begin
                        if (cfg.parity_en) begin
                            state_n = ST_PARITY;
                            tx_n    = cfg.parity_bit;
                        end else begin
                            state_n = ST_STOP;
                            tx_n    = 1'b1;
                            extra_n = cfg.stop2;
                        end
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                        shreg_n   = shreg >> 1;
                        tx_n      = shreg_n[0];
                    end
                end
            end

            ST_PARITY: begin
                if (timer_done) begin
                    state_n = ST_STOP;
                    timer_n = TIMER_LOAD;
                    tx_n    = 1'b1;
                    extra_n = cfg.stop2;
                end
            end

            // Last stop bit hands straight to the next frame: no idle gap
            ST_STOP: begin
                if (timer_done) begin
                    if (extra) begin
                        extra_n = 1'b0;
                        timer_n = TIMER_LOAD;
                    end else begin
                        dispatch = 1'b1;
                    end
                end
            end

            // Low for at least one bit time and until the request drops,
            // then two bit times of mark
            ST_BREAK: begin
                if (!brk_mark) begin
                    if (timer_done && !break_req) begin
                        brk_mark_n = 1'b1;
                        extra_n    = 1'b1;
                        timer_n    = TIMER_LOAD;
                        tx_n       = 1'b1;
                    end
                end else if (timer_done) begin
                    if (extra) begin
                        extra_n = 1'b0;
                        timer_n = TIMER_LOAD;
                    end else begin
                        brk_mark_n = 1'b0;
                        state_n    = ST_IDLE;
                        tx_n       = 1'b1;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Start of the next activity: break wins over buffered data
        if (dispatch) begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
            if (break_req) begin
                state_n    = ST_BREAK;
                timer_n    = TIMER_LOAD;
                tx_n       = 1'b0;
                brk_mark_n = 1'b0;
                extra_n    = 1'b0;
            end else if (!fifo_empty) begin
                fifo_pop         = 1'b1;
                state_n          = ST_START;
                timer_n          = TIMER_LOAD;
                tx_n             = 1'b0;
                shreg_n          = fifo_rd_data;
                cfg_n.parity_en  = parity_en;
                cfg_n.parity_bit = (^fifo_rd_data) ^ parity_mode;
                cfg_n.stop2      = stop_bits;
            end
        end
    end

endmodule
